pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed ID/EX pipeline register: one generic inter-stage register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a payload word plus a control word using a valid/ready handshake.
- Supports an optional 2-entry skid buffer, per-transfer control kill (bubble injection) and a whole-stage flush.
- Provides saturating stall and bubble counters for the FFT/IFFT kernel performance probes.

---
 rtl/pipe_stage_buf.sv | 192 +++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register carrying payload + control with valid/ready, kill and flush.
// Latency: 1 cycle push->out_valid; 1 entry/cycle sustained throughput with out_ready held high.
// Backpressure: SKID=1 absorbs one extra entry and drives a registered in_ready; SKID=0 uses combinational in_ready.
module pipe_stage_buf #(
    parameter int                 DATA_W    = 128,
    parameter int                 CTRL_W    = 16,
    parameter logic [CTRL_W-1:0]  KILL_MASK = '0,
    parameter int                 SKID      = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_kill,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Main output register: this is what the downstream stage sees.
    logic              main_vld;
    logic [DATA_W-1:0] main_dat;
    logic [CTRL_W-1:0] main_ctl;

    // Handshake qualifiers; flush wins over any same-cycle transfer.
    logic              push;
    logic              pop;
    logic [CTRL_W-1:0] wr_ctl;

    // Performance counters.
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  bubble_q;
    logic              stall_evt;
    logic              bubble_evt;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = main_vld & out_ready;

    // Killed entries have their masked control bits cleared before they are
    // written, so a partially masked word never reaches the output.
    assign wr_ctl = in_kill ? (in_ctrl & ~KILL_MASK) : in_ctrl;

    assign out_valid = main_vld;
    assign out_data  = main_dat;
    assign out_ctrl  = main_ctl;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t            state_q;
            logic              rdy_q;
            logic              skid_vld;
            logic [DATA_W-1:0] skid_dat;
            logic [CTRL_W-1:0] skid_ctl;

            // rdy_q tracks (next state != FULL) so in_ready is a clean flop output.
            assign in_ready = rdy_q;

            // Two-entry FSM: the main register always holds the older entry,
            // the skid register only fills when the main entry is stalled.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q  <= ST_EMPTY;
                    rdy_q    <= 1'b0;
                    main_vld <= 1'b0;
                    main_dat <= '0;
                    main_ctl <= '0;
                    skid_vld <= 1'b0;
                    skid_dat <= '0;
                    skid_ctl <= '0;
                end else if (flush) begin
                    state_q  <= ST_EMPTY;
                    rdy_q    <= 1'b1;
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            rdy_q <= 1'b1;
                            if (push) begin
                                main_vld <= 1'b1;
                                main_dat <= in_data;
                                main_ctl <= wr_ctl;
                                state_q  <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (push && pop) begin
                                main_dat <= in_data;
                                main_ctl <= wr_ctl;
                                rdy_q    <= 1'b1;
                            end else if (push) begin
                                skid_vld <= 1'b1;
                                skid_dat <= in_data;
                                skid_ctl <= wr_ctl;
                                state_q  <= ST_FULL;
                                rdy_q    <= 1'b0;
                            end else if (pop) begin
                                main_vld <= 1'b0;
                                state_q  <= ST_EMPTY;
                                rdy_q    <= 1'b1;
                            end else begin
                                rdy_q    <= 1'b1;
                            end
                        end
                        ST_FULL: begin
                            // in_ready is low here, so only a pop can happen.
                            if (pop) begin
                                main_dat <= skid_dat;
                                main_ctl <= skid_ctl;
                                skid_vld <= 1'b0;
                                state_q  <= ST_ONE;
                                rdy_q    <= 1'b1;
                            end else begin
                                rdy_q    <= 1'b0;
                            end
                        end
                        default: begin
                            state_q  <= ST_EMPTY;
                            rdy_q    <= 1'b1;
                            main_vld <= 1'b0;
                            skid_vld <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // Accept whenever the slot is empty or is being drained this cycle;
            // held low while reset is asserted.
            assign in_ready = rst & (~main_vld | out_ready);

            // Single register: load on push, empty on pop without push.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_vld <= 1'b0;
                    main_dat <= '0;
                    main_ctl <= '0;
                end else if (flush) begin
                    main_vld <= 1'b0;
                end else if (push) begin
                    main_vld <= 1'b1;
                    main_dat <= in_data;
                    main_ctl <= wr_ctl;
                end else if (pop) begin
                    main_vld <= 1'b0;
                end
            end
        end
    endgenerate

    assign stall_evt  = main_vld & ~out_ready & ~flush;
    assign bubble_evt = push & in_kill;

    // Saturating stall counter; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (cnt_clr) begin
            stall_q <= '0;
        end else if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Saturating bubble counter; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
        end else if (cnt_clr) begin
            bubble_q <= '0;
        end else if (bubble_evt && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_q <= bubble_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid and single-register variants against a queue model.
// Latency: model tracks entries per cycle; outputs compared 2 time units after each clock edge.
// Backpressure: randomized out_ready/flush/kill traffic plus directed stall, flush and reset steps.
module tb_pipe_stage_buf;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;
    localparam logic [CW-1:0] KM = 16'h001F;
    localparam int CMAX = (1 << NW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_kill;
    logic          flush;
    logic          out_ready;
    logic          cnt_clr;

    logic          rdy_a, vld_a, rdy_b, vld_b;
    logic [DW-1:0] dat_a, dat_b;
    logic [CW-1:0] ctl_a, ctl_b;
    logic [NW-1:0] stl_a, stl_b, bub_a, bub_b;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KM), .SKID(1), .CNT_W(NW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_kill(in_kill), .flush(flush), .out_valid(vld_a),
        .out_ready(out_ready), .out_data(dat_a), .out_ctrl(ctl_a), .cnt_clr(cnt_clr),
        .stall_cnt(stl_a), .bubble_cnt(bub_a)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KM), .SKID(0), .CNT_W(NW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_kill(in_kill), .flush(flush), .out_valid(vld_b),
        .out_ready(out_ready), .out_data(dat_b), .out_ctrl(ctl_b), .cnt_clr(cnt_clr),
        .stall_cnt(stl_b), .bubble_cnt(bub_b)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Reference model: an ordered queue per variant plus plain counters.
    ent_t qa[$];
    ent_t qb[$];
    int   sa, sb, ba, bb;
    bit   ra_ok;
    int   total, bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rdy_a();
        return ra_ok && (qa.size() < 2);
    endfunction

    function automatic bit exp_rdy_b();
        return rst && ((qb.size() == 0) || out_ready);
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        sa = 0; sb = 0; ba = 0; bb = 0;
        ra_ok = 0;
    endtask

    task automatic check_outputs();
        chk("rdy_a", rdy_a, exp_rdy_a());
        chk("vld_a", vld_a, qa.size() > 0);
        if (qa.size() > 0) begin
            chk("dat_a", dat_a, qa[0].d);
            chk("ctl_a", ctl_a, qa[0].c);
        end
        chk("stall_a", stl_a, sa);
        chk("bubble_a", bub_a, ba);
        chk("rdy_b", rdy_b, exp_rdy_b());
        chk("vld_b", vld_b, qb.size() > 0);
        if (qb.size() > 0) begin
            chk("dat_b", dat_b, qb[0].d);
            chk("ctl_b", ctl_b, qb[0].c);
        end
        chk("stall_b", stl_b, sb);
        chk("bubble_b", bub_b, bb);
    endtask

    // Check current outputs, clock once, then advance the model from the sampled inputs.
    task automatic tick();
        bit   pa, pb, oa, ob, st_a, st_b, fl, clr, kl, r;
        ent_t e;
        #1;
        check_outputs();
        r   = rst;
        fl  = flush;
        clr = cnt_clr;
        kl  = in_kill;
        e.d = in_data;
        e.c = in_kill ? (in_ctrl & ~KM) : in_ctrl;
        pa  = in_valid && exp_rdy_a() && !flush;
        pb  = in_valid && exp_rdy_b() && !flush;
        oa  = (qa.size() > 0) && out_ready;
        ob  = (qb.size() > 0) && out_ready;
        st_a = (qa.size() > 0) && !out_ready && !flush;
        st_b = (qb.size() > 0) && !out_ready && !flush;
        @(posedge clk);
        if (!r) begin
            model_clear();
        end else begin
            if (clr) begin
                sa = 0; sb = 0; ba = 0; bb = 0;
            end else begin
                if (st_a && sa < CMAX) sa++;
                if (st_b && sb < CMAX) sb++;
                if (pa && kl && ba < CMAX) ba++;
                if (pb && kl && bb < CMAX) bb++;
            end
            if (fl) begin
                qa.delete();
                qb.delete();
            end else begin
                if (oa) void'(qa.pop_front());
                if (ob) void'(qb.pop_front());
                if (pa) qa.push_back(e);
                if (pb) qb.push_back(e);
            end
            ra_ok = 1;
        end
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic k);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        in_kill  = k;
        tick();
        in_valid = 1'b0;
        in_kill  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_kill = 1'b0;
        flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;

        // Reset state.
        #3;
        chk("rst_dat_a", dat_a, 0);
        chk("rst_ctl_a", ctl_a, 0);
        chk("rst_dat_b", dat_b, 0);
        chk("rst_ctl_b", ctl_b, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();

        // Back-to-back pushes 0..7 with out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(i);
            in_ctrl = CW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Two entries into a stalled stage, then drain in order.
        out_ready = 1'b0;
        offer(32'hAAAA_0001, 16'h1234, 1'b0);
        offer(32'hBBBB_0002, 16'h5678, 1'b0);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Killed transfer: mask clears the low five control bits.
        offer(32'hC0DE_0003, 16'hFFFF, 1'b1);
        chk("kill_ctl", ctl_a, 16'hFFE0);
        chk("kill_dat", dat_a, 32'hC0DE_0003);
        tick();
        tick();

        // Flush while full with a competing offer.
        out_ready = 1'b0;
        offer(32'h0000_00A1, 16'h0011, 1'b0);
        offer(32'h0000_00B2, 16'h0022, 1'b0);
        flush = 1'b1;
        offer(32'hDEAD_BEEF, 16'h0033, 1'b0);
        flush = 1'b0;
        chk("flush_vld", vld_a, 1'b0);
        chk("flush_rdy", rdy_a, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();

        // Long stall to saturate, then clear in a stall cycle.
        out_ready = 1'b0;
        offer(32'h5A5A_0004, 16'h0044, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_sat", stl_a, CMAX);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("stall_clr", stl_a, 0);
        out_ready = 1'b1;
        tick();
        tick();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_kill   = ($urandom_range(4) == 0);
            flush     = ($urandom_range(22) == 0);
            cnt_clr   = ($urandom_range(40) == 0);
            in_data   = DW'($urandom);
            in_ctrl   = CW'($urandom);
            tick();
        end
        in_valid = 1'b0; in_kill = 1'b0; flush = 1'b0; cnt_clr = 1'b0;

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        tick();
        tick();
        offer(32'h0000_0E01, 16'h0101, 1'b1);
        offer(32'h0000_0E02, 16'h0202, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        model_clear();
        check_outputs();
        tick();
        rst = 1'b1;
        tick();
        tick();
        out_ready = 1'b1;
        offer(32'h0000_0F01, 16'h0303, 1'b0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
